tanh_in_quant_4bit: RTL and testbench

Upstream feeder for the 4-bit approximate tanh circuits. It accepts signed fixed-point pre-activation samples over a valid/ready stream, takes their magnitude, then rounds and saturates each one to the 4-bit unsigned Q2.2 code those circuits consume. The sign goes out as a separate bit so the downstream odd-symmetry stage can re-apply it. A 2-stage pipeline gives full throughput under backpressure, and a saturation counter supports range diagnostics.

---
 rtl/tanh_act_pkg.sv | 18 +
 rtl/tanh4_quant.sv | 30 +++
 rtl/tanh_in_quant_4bit.sv | 117 +++++++++++
 tb/tb_tanh_in_quant_4bit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_act_pkg.sv
// Shared definitions for the 4-bit approximate tanh datapath: code format
// constants and the sample record passed between the quantiser and the
// downstream sign-restore stage.
package tanh_act_pkg;

  localparam int TANH_CODE_W    = 4;
  localparam int TANH_CODE_FRAC = 2;
  localparam int TANH_CODE_MAX  = 15;

  typedef logic [TANH_CODE_W-1:0] tanh_code_t;

  typedef struct packed {
    tanh_code_t code;
    logic       sign;
    logic       sat;
  } tanh_samp_t;

endpackage

// File: rtl/tanh4_quant.sv
// Combinational magnitude quantiser: rounds an unsigned fixed-point magnitude
// half-up to Q2.2 and clips anything above 3.75 to the top code.
module tanh4_quant
  import tanh_act_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 12
) (
  input  logic [IN_W-1:0] mag,
  output tanh_code_t      code,
  output logic            sat
);

  localparam int SHIFT = FRAC_W - TANH_CODE_FRAC;
  // Half of one output LSB, expressed in input LSBs.
  localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  // One extra bit so the rounding add cannot overflow for 2^(IN_W-1).
  logic [IN_W:0] sum;
  logic [IN_W:0] q;

  // Round half-up, then saturate anything that does not fit in the code.
  always_comb begin
    sum  = {1'b0, mag} + HALF;
    q    = sum >> SHIFT;
    sat  = |q[IN_W:TANH_CODE_W];
    code = sat ? tanh_code_t'(TANH_CODE_MAX) : q[TANH_CODE_W-1:0];
  end

endmodule

// File: rtl/tanh_in_quant_4bit.sv
// Input feeder for the 4-bit tanh circuits: two-stage valid/ready pipeline
// (magnitude/sign, then round/saturate) with a saturating event counter.
module tanh_in_quant_4bit
  import tanh_act_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_code,
  output logic             out_sign,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic [IN_W-1:0] ONE_IN = {{(IN_W-1){1'b0}}, 1'b1};

  logic            s1_valid;
  logic [IN_W-1:0] s1_mag;
  logic            s1_sign;

  logic            s2_valid;
  tanh_samp_t      s2_q;

  logic [IN_W-1:0] in_mag;
  tanh_code_t      q_code;
  logic            q_sat;
  tanh_samp_t      s1_samp;
  logic            hold2;
  logic            out_fire;

  logic [CNT_W-1:0] sat_count_q;

  // Absolute value; the most negative input maps to 2^(IN_W-1) as unsigned.
  always_comb begin
    in_mag = in_data[IN_W-1] ? ((~in_data) + ONE_IN) : in_data;
  end

  tanh4_quant #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W)
  ) u_quant (
    .mag  (s1_mag),
    .code (q_code),
    .sat  (q_sat)
  );

  // Assemble the stage-2 record; a zero code never carries a minus sign.
  always_comb begin
    s1_samp      = '0;
    s1_samp.code = q_code;
    s1_samp.sat  = q_sat;
    s1_samp.sign = s1_sign & (q_code != '0);
  end

  // Stall decode: stage 2 holds while presented and not taken.
  always_comb begin
    hold2    = s2_valid & ~out_ready;
    in_ready = rst_n & ~(s1_valid & hold2);
    out_fire = s2_valid & out_ready;
  end

  // Stage 1: capture magnitude and sign whenever the block accepts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_sign  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mag  <= in_mag;
        s1_sign <= in_data[IN_W-1];
      end
    end
  end

  // Stage 2: take the quantised sample unless the consumer is stalling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (!hold2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q <= s1_samp;
      end
    end
  end

  // Saturation counter: counts delivered clipped samples, sticks at all-ones,
  // and a clear request beats a simultaneous increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count_q <= '0;
    end else if (sat_clr) begin
      sat_count_q <= '0;
    end else if (out_fire && s2_q.sat && (sat_count_q != '1)) begin
      sat_count_q <= sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = s2_valid;
  assign out_code  = s2_q.code;
  assign out_sign  = s2_q.sign;
  assign out_sat   = s2_q.sat;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_tanh_in_quant_4bit.sv
// Self-checking bench for tanh_in_quant_4bit: directed literal values,
// randomized streaming under backpressure against a queue-based model,
// counter saturation on a narrow-counter instance, and mid-stream reset.
module tb_tanh_in_quant_4bit;

  localparam int IN_W   = 16;
  localparam int FRAC_W = 12;
  localparam int CNT_W  = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_code;
  logic        out_sign;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
  logic        sat_clr;
  logic [15:0] sat_count;

  logic [15:0] in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic [3:0]  out_code2;
  logic        out_sign2;
  logic        out_sat2;
  logic        out_valid2;
  logic        out_ready2;
  logic        sat_clr2;
  logic [1:0]  sat_count2;

  int checks = 0;
  int errors = 0;

  tanh_in_quant_4bit #(.IN_W(IN_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_code(out_code), .out_sign(out_sign),
    .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  tanh_in_quant_4bit #(.IN_W(IN_W), .FRAC_W(FRAC_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out_code(out_code2), .out_sign(out_sign2),
    .out_sat(out_sat2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sat_clr(sat_clr2), .sat_count(sat_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value -> packed {code[3:0], sign, sat} from plain arithmetic.
  function automatic int model(input logic [15:0] d);
    int v, m, q, code, sign, sat;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    q = (m + (1 << (FRAC_W - 3))) / (1 << (FRAC_W - 2));
    sat  = (q > 15) ? 1 : 0;
    code = (q > 15) ? 15 : q;
    sign = ((v < 0) && (code != 0)) ? 1 : 0;
    return code * 4 + sign * 2 + sat;
  endfunction

  function automatic logic [15:0] rand_sample();
    int b;
    case ($urandom % 5)
      0: b = int'($urandom_range(0, 65535));
      1: b = ($urandom % 2) ? 32767 : -32768;
      2: begin
        b = int'($urandom_range(0, 63)) * 512 + int'($urandom_range(0, 2)) - 1;
        if ($urandom % 2) b = -b;
      end
      3: b = int'($urandom_range(0, 1200)) - 600;
      default: b = int'($urandom_range(14000, 17000)) * (($urandom % 2) ? 1 : -1);
    endcase
    return 16'(b);
  endfunction

  // Scoreboard state for the main instance.
  int   sb[$];
  int   model_cnt = 0;
  logic last_acc = 1'b0;
  logic prev_stall = 1'b0;
  int   prev_out = 0;

  // Per-cycle comparison, sampled mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    int exp_v, cur;
    cur = {27'd0, out_valid, out_code, out_sign, out_sat};
    if (rst_n) begin
      check("in_ready", int'(in_ready), (sb.size() == 2 && !out_ready) ? 0 : 1);
      if (prev_stall) check("stall_stable", cur, prev_out);
      check("sat_count", int'(sat_count), model_cnt);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          exp_v = sb.pop_front();
          check("out_sample", int'({out_code, out_sign, out_sat}), exp_v);
          if (sat_clr) model_cnt = 0;
          else if ((exp_v % 2) == 1 && model_cnt < 65535) model_cnt++;
        end
      end else if (sat_clr) begin
        model_cnt = 0;
      end
      if (in_valid && in_ready) sb.push_back(model(in_data));
      last_acc   = in_valid && in_ready;
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
    end else begin
      check("in_ready_rst", int'(in_ready), 0);
      sb.delete();
      model_cnt  = 0;
      last_acc   = 1'b0;
      prev_stall = 1'b0;
    end
  end

  // One sample into an idle pipeline; checks latency and literal result.
  task automatic send_and_check(input logic [15:0] d, input int code, input int sign,
                                input int sat, input string name);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, int'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_code"}, int'({out_code, out_sign, out_sat}), code * 4 + sign * 2 + sat);
  endtask

  task automatic send2(input logic [15:0] d);
    @(posedge clk); #1;
    in_valid2 = 1'b1;
    in_data2  = d;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    in_data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1; sat_clr2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", int'({out_valid, out_code, out_sign, out_sat}), 0);
    check("rst_cnt", int'(sat_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed values pinned to hand-computed codes.
    send_and_check(16'h1000, 4, 0, 0, "one");
    send_and_check(16'hFA00, 2, 1, 0, "neg_0p375");
    send_and_check(16'h0200, 1, 0, 0, "half_up");
    send_and_check(16'h01FF, 0, 0, 0, "below_half");
    send_and_check(16'hFE01, 0, 0, 0, "neg_zero");
    send_and_check(16'hFE00, 1, 1, 0, "neg_half");
    send_and_check(16'h7FFF, 15, 0, 1, "max_pos");
    send_and_check(16'h8000, 15, 1, 1, "max_neg");
    send_and_check(16'h3C00, 15, 0, 0, "top_exact");
    @(posedge clk);
    @(negedge clk);
    check("sat_cnt_two", int'(sat_count), 2);

    // Randomized streaming with backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!(in_valid && !last_acc)) begin
        in_valid = (i < 40) ? 1'b1 : (($urandom % 4) != 0);
        in_data  = rand_sample();
      end
      out_ready = ($urandom % 3) != 0;
      sat_clr   = ($urandom % 16) == 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_empty", sb.size(), 0);

    // Mid-stream reset with both stages full and stalled.
    send_and_check(16'h8000, 15, 1, 1, "pre_rst");
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h7FFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("full_in_ready", int'(in_ready), 0);
    check("full_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_cnt", int'(sat_count), 0);
    send_and_check(16'h1000, 4, 0, 0, "post_rst");
    @(posedge clk);

    // Narrow counter: hold at the top, then clear versus increment.
    for (int k = 0; k < 5; k++) send2(16'h8000);
    @(negedge clk);
    check("cnt2_hold", int'(sat_count2), 3);
    @(posedge clk); #1;
    sat_clr2 = 1'b1;
    @(posedge clk); #1;
    sat_clr2 = 1'b0;
    @(negedge clk);
    check("cnt2_clear", int'(sat_count2), 0);
    send2(16'h7FFF);
    @(negedge clk);
    check("cnt2_one", int'(sat_count2), 1);
    @(posedge clk); #1;
    in_valid2 = 1'b1;
    in_data2  = 16'h8000;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    sat_clr2 = 1'b1;
    @(negedge clk);
    check("cnt2_hs_valid", int'({out_valid2, out_sat2}), 3);
    @(posedge clk); #1;
    sat_clr2 = 1'b0;
    @(negedge clk);
    check("cnt2_clr_wins", int'(sat_count2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
